// File: rtl/sdram_read_arbiter_if.sv
// Bundle of requester, SDRAM read-wrapper and response signals around the read arbiter.
// The arbiter uses the slave view; the environment driving it uses the master view.
interface sdram_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [LEN_W-1:0]          mem_req_len;
    logic                      mem_rdata_valid;
    logic [DATA_W-1:0]         mem_rdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      rsp_last;
    logic [DATA_W-1:0]         rsp_data;
    logic                      err_unexpected;

    modport slave (
        input  req_valid, req_addr, req_len, mem_req_ready, mem_rdata_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_req_addr, mem_req_len,
               rsp_valid, rsp_last, rsp_data, err_unexpected
    );

    modport master (
        output req_valid, req_addr, req_len, mem_req_ready, mem_rdata_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_req_addr, mem_req_len,
               rsp_valid, rsp_last, rsp_data, err_unexpected
    );
endinterface

// File: rtl/sdram_read_arbiter.sv
// Round-robin sharing of one SDRAM burst-read port among NUM_REQ requesters; returning
// beats are steered to their issuer through an in-order {id, len} tag FIFO.
module sdram_read_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int LEN_W           = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                 clk,
    input logic                 rst,
    sdram_read_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_last_q, rsp_last_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   id_mem  [MAX_OUTSTANDING];
    logic [LEN_W-1:0]   len_mem [MAX_OUTSTANDING];

    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic [LEN_W-1:0]     len_arr  [NUM_REQ];
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     win_off;
    logic [IDX_W:0]       win_sum;
    logic [IDX_W-1:0]     win_id;
    logic                 win_found;
    logic                 grant_en;
    logic                 push;
    logic                 pop;
    logic                 beat_hit;
    logic                 beat_last;
    logic [IDX_W-1:0]     head_id;
    logic [LEN_W-1:0]     head_len;
    logic [NUM_REQ-1:0]   rsp_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign addr_arr[gi]      = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign len_arr[gi]       = bus.req_len[gi*LEN_W +: LEN_W];
        assign bus.req_ready[gi] = grant_en && (win_id == IDX_W'(gi));
        assign rsp_sel[gi]       = (head_id == IDX_W'(gi));
    end

    // Rotate the request vector so that bit 0 is the requester at the RR pointer.
    assign req_dbl = {bus.req_valid, bus.req_valid};
    assign req_rot = NUM_REQ'(req_dbl >> rr_q);

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = IDX_W'(k);
            end
        end
    end

    assign win_sum  = {1'b0, rr_q} + {1'b0, win_off};
    assign win_id   = (win_sum >= NUM_EXT) ? IDX_W'(win_sum - NUM_EXT) : IDX_W'(win_sum);
    // A granted command already owns its FIFO slot, so only pushed entries count here.
    assign grant_en = !rst && (state_q == IDLE) && win_found && (cnt_q != CNT_FULL);
    assign push     = (state_q == ISSUE) && bus.mem_req_ready;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_id_d = gnt_id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    gnt_id_d = win_id;
                    addr_d   = addr_arr[win_id];
                    len_d    = len_arr[win_id];
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (push) begin
                    rr_d    = (gnt_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign head_id   = id_mem[rd_ptr_q];
    assign head_len  = len_mem[rd_ptr_q];
    assign beat_hit  = bus.mem_rdata_valid && (cnt_q != '0);
    assign beat_last = (beat_q == head_len);
    assign pop       = beat_hit && beat_last;

    always_comb begin
        rsp_valid_d = '0;
        rsp_last_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        beat_d      = beat_q;
        err_d       = err_q | (bus.mem_rdata_valid && (cnt_q == '0));
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (beat_hit) begin
            rsp_valid_d = rsp_sel;
            rsp_last_d  = beat_last;
            rsp_data_d  = bus.mem_rdata;
            beat_d      = beat_last ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q]  <= gnt_id_q;
            len_mem[wr_ptr_q] <= len_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            gnt_id_q    <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_q      <= '0;
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_id_q    <= gnt_id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_q      <= beat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_req_valid  = (state_q == ISSUE);
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_len    = len_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_last       = rsp_last_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.err_unexpected = err_q;
endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
- Shares the single SDRAM read port (sdram_read_wrapper side) among NUM_REQ requesters, e.g. CPU instruction fetch and NPU weight/activation loader.
- Arbitrates burst read commands round-robin and registers the granted command toward memory.
- Routes returning read beats to the requester that issued them, using an in-order tag FIFO.
- Sits between design_top's requesters and the SDRAM read wrapper.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, byte address width
DATA_W, 32, read data width
LEN_W, 8, burst length field; value L means L+1 beats
MAX_OUTSTANDING, 4, tag FIFO depth (power of 2), max in-flight bursts

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  per-requester command accepted
req_addr  in  NUM_REQ*ADDR_W  packed command addresses, requester i at slice i
req_len  in  NUM_REQ*LEN_W  packed burst lengths (beats-1)
mem_req_valid  out  1  command to SDRAM read wrapper
mem_req_ready  in  1  wrapper accepts command
mem_req_addr  out  ADDR_W  granted address
mem_req_len  out  LEN_W  granted length
mem_rdata_valid  in  1  read beat from wrapper; no backpressure
mem_rdata  in  DATA_W  read beat data
rsp_valid  out  NUM_REQ  one-hot beat strobe to owning requester
rsp_last  out  1  final beat of burst
rsp_data  out  DATA_W  beat data, broadcast to all requesters
err_unexpected  out  1  sticky: beat received with no burst outstanding

Behaviour:
- Reset (async, rst=1): all outputs 0; RR pointer = 0; tag FIFO empty; beat counter 0; FSM = IDLE. rst mid-burst drops all in-flight state. Beats arriving after reset release with an empty FIFO set err_unexpected.
- Command FSM: IDLE, ISSUE.
- IDLE:
  - If any req_valid and the FIFO is not full, grant the lowest index at or after the RR pointer with req_valid=1.
  - Pulse req_ready[g]=1 in the same cycle (combinational from req_valid, FIFO count and state; no other ready high).
  - Latch addr, len and g; go to ISSUE.
  - If the FIFO is full, all req_ready=0 and stay in IDLE.
- ISSUE:
  - mem_req_valid=1; addr and len held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready: push {g, len} to the FIFO, set RR pointer = (g+1) mod NUM_REQ, go to IDLE.
  - Minimum spacing is 2 cycles per command.
- Since one command reserves its FIFO slot at grant, FIFO occupancy (including the command in ISSUE) never exceeds MAX_OUTSTANDING.
- Response path:
  - Head entry {id, len}; beat counter starts at 0.
  - Each mem_rdata_valid with FIFO non-empty: rsp_valid = onehot(id) and rsp_data = mem_rdata, both registered, so latency is 1 cycle.
  - If counter == len: rsp_last=1, pop head, counter = 0. Otherwise counter++.
- mem_rdata_valid with FIFO empty: beat dropped, rsp_valid stays 0, err_unexpected set to 1 until reset.
- Push and pop in the same cycle are allowed; count is unchanged.
- A pop in cycle t frees a slot for a grant in cycle t+1, not the same cycle.
- len=0 is a single-beat burst; rsp_last is asserted on that beat.
- Maximum len (2^LEN_W-1) gives 2^LEN_W beats; the counter is LEN_W bits and must not overflow before the compare.
- Requesters hold req_valid/addr/len until req_ready. Deasserting before grant is permitted and simply loses arbitration.

Test Plan:
- Single request: req_valid[0]=1, addr=0x100, len=3, mem_req_ready=1 in ISSUE. Required:
  - req_ready[0] pulses once.
  - mem_req_addr=0x100, len=3.
  - 4 beats 0xA0..0xA3 -> rsp_valid=2'b01 on each one cycle later, rsp_last on 0xA3.
- Contention: both requesters valid continuously, mem_req_ready=1. Required: grant order 0,1,0,1 and each req_ready high exactly in its grant cycle.
- Backpressure: mem_req_ready=0 for 5 cycles in ISSUE. Required: mem_req_addr/len stable, no new grant, FIFO count unchanged until the handshake.
- FIFO full: 4 commands issued with no beats returned. Required: req_ready=0 while req_valid=1. Return a 1-beat burst (len=0) -> a grant occurs the next cycle.
- Interleaved ownership: issue r0 len=1 then r1 len=0, return 3 beats. Required: rsp_valid = 01, 01 (last), 10 (last).
- Error and reset: mem_rdata_valid with FIFO empty -> err_unexpected=1 and sticky. Assert rst mid-burst -> all outputs 0 immediately (asynchronous), FSM IDLE, FIFO empty.
